// File: rtl/fetch_pkg.sv
// Shared constants, slot record and the RVC length test used by the fetch aligner.
package fetch_pkg;
  localparam int WORD = 32;
  localparam int HALF = 16;

  typedef struct packed {
    logic [WORD-1:0] insn;
    logic            compressed;
  } slot_t;

  function automatic logic is_compressed(input logic [HALF-1:0] h);
    return h[1:0] != 2'b11;
  endfunction
endpackage

// File: rtl/boundary_scan.sv
// Combinational boundary finder: up to DECODE instruction starts from ptr, zero latency, no handshake.
// FETCH_ALIGN_CARRY_EN: a 32-bit op in the last half is held back as a straddler instead of issued alone.
module boundary_scan
  import fetch_pkg::*;
#(
  parameter int  WIDTH  = 4,
  parameter int  DECODE = 4,
  localparam int DWIDTH = 2 * WIDTH,
  localparam int PW     = $clog2(DWIDTH + 1),
  localparam int IW     = $clog2(DWIDTH)
) (
  input  logic [WORD*WIDTH-1:0] pkt_buf,
  input  logic [PW-1:0]         ptr,
  input  logic                  carry_v,
  output logic [DECODE*IW-1:0]  start,
  output logic [DECODE-1:0]     valid,
  output logic [DECODE-1:0]     compressed,
  output logic [PW-1:0]         consumed,
  output logic                  straddle
);

  logic [HALF-1:0] halves [DWIDTH];
  logic [PW-1:0]   pos;

  always_comb begin
    for (int i = 0; i < DWIDTH; i++) halves[i] = pkt_buf[HALF*i +: HALF];
  end

  always_comb begin
    start      = '0;
    valid      = '0;
    compressed = '0;
    straddle   = 1'b0;
    pos        = ptr;
    // Slot 0 is the held low half joined with half 0; scanning resumes at half 1.
    if (carry_v && ptr == '0) begin
      valid[0] = 1'b1;
      pos      = PW'(1);
    end
    for (int k = 0; k < DECODE; k++) begin
      if (!valid[k] && pos < PW'(DWIDTH)) begin
        if (is_compressed(halves[pos[IW-1:0]])) begin
          valid[k]               = 1'b1;
          compressed[k]          = 1'b1;
          start[k*IW +: IW]      = pos[IW-1:0];
          pos                    = pos + PW'(1);
        end else if (pos < PW'(DWIDTH - 1)) begin
          valid[k]               = 1'b1;
          start[k*IW +: IW]      = pos[IW-1:0];
          pos                    = pos + PW'(2);
        end else begin
`ifndef FETCH_ALIGN_CARRY_EN
          valid[k]               = 1'b1;
          start[k*IW +: IW]      = pos[IW-1:0];
          straddle               = 1'b1;
          pos                    = pos + PW'(1);
`endif
        end
      end
    end
`ifdef FETCH_ALIGN_CARRY_EN
    // Seen even when the slots fill exactly up to it, so the capture rides the same transfer.
    if (pos == PW'(DWIDTH - 1) && !is_compressed(halves[DWIDTH-1])) straddle = 1'b1;
`endif
    consumed = pos - ptr;
  end

endmodule

// File: rtl/fetch_align.sv
// Fetch-packet aligner: packet accepted at N issues up to DECODE slots at N+1; outputs hold while i_ready=0.
// Packet accepted only when empty or draining; FETCH_ALIGN_CARRY_EN enables the cross-packet straddle carry.
module fetch_align
  import fetch_pkg::*;
#(
  parameter int  WIDTH  = 4,
  parameter int  DECODE = 4,
  localparam int DWIDTH = 2 * WIDTH,
  localparam int PW     = $clog2(DWIDTH + 1),
  localparam int IW     = $clog2(DWIDTH),
  localparam int CW     = $clog2(DECODE + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [WORD*WIDTH-1:0]  i_packet,
  input  logic                   i_packet_valid,
  output logic                   o_packet_ready,
  input  logic                   i_flush,
  input  logic [IW-1:0]          i_flush_offset,
  output logic [WORD*DECODE-1:0] o_insn,
  output logic [DECODE-1:0]      o_valid,
  output logic [DECODE-1:0]      o_compressed,
  output logic [CW-1:0]          o_count,
  input  logic                   i_ready
`ifndef FETCH_ALIGN_CARRY_EN
  ,
  output logic                   o_straddle_fault
`endif
);

  logic [WORD*WIDTH-1:0] pkt_buf;
  logic                  full;
  logic [PW-1:0]         ptr;
  logic [IW-1:0]         pend_off;
`ifdef FETCH_ALIGN_CARRY_EN
  logic [HALF-1:0]       carry;
  logic                  carry_v;
`endif

  logic                  join_v;
  logic [DECODE*IW-1:0]  start;
  logic [DECODE-1:0]     valid;
  logic [DECODE-1:0]     compressed;
  logic [PW-1:0]         consumed;
  logic                  straddle;
  logic [PW-1:0]         next_ptr;
  logic                  xfer;
  logic                  drain;
  logic                  accept;
  logic [IW-1:0]         sidx;
  logic [HALF-1:0]       halves [DWIDTH];
  slot_t                 slots  [DECODE];

`ifdef FETCH_ALIGN_CARRY_EN
  assign join_v = carry_v && (ptr == '0);
`else
  assign join_v = 1'b0;
`endif

  boundary_scan #(.WIDTH(WIDTH), .DECODE(DECODE)) u_scan (
    .pkt_buf    (pkt_buf),
    .ptr        (ptr),
    .carry_v    (join_v),
    .start      (start),
    .valid      (valid),
    .compressed (compressed),
    .consumed   (consumed),
    .straddle   (straddle)
  );

  assign xfer     = full && valid[0] && i_ready;
  assign next_ptr = ptr + consumed;
`ifdef FETCH_ALIGN_CARRY_EN
  // A zero-slot scan means only a straddler is left: capture it and free the buffer.
  assign drain    = full && ((xfer && (next_ptr == PW'(DWIDTH) || straddle)) || !valid[0]);
`else
  assign drain    = full && ((xfer && next_ptr == PW'(DWIDTH)) || !valid[0]);
  assign o_straddle_fault = full && straddle;
`endif
  assign o_packet_ready = !i_flush && (!full || drain);
  assign accept         = i_packet_valid && o_packet_ready;

  always_comb begin
    for (int i = 0; i < DWIDTH; i++) halves[i] = pkt_buf[HALF*i +: HALF];
  end

  always_comb begin
    o_insn       = '0;
    o_valid      = '0;
    o_compressed = '0;
    o_count      = '0;
    sidx         = '0;
    for (int k = 0; k < DECODE; k++) begin
      slots[k] = '0;
      sidx     = start[k*IW +: IW];
      if (full && valid[k]) begin
        slots[k].compressed = compressed[k];
`ifdef FETCH_ALIGN_CARRY_EN
        if (k == 0 && join_v) slots[k].insn = {halves[0], carry};
        else
`endif
        if (compressed[k] || sidx == IW'(DWIDTH - 1)) slots[k].insn = {{HALF{1'b0}}, halves[sidx]};
        else slots[k].insn = {halves[sidx + IW'(1)], halves[sidx]};
      end
      o_insn[k*WORD +: WORD] = slots[k].insn;
      o_compressed[k]        = slots[k].compressed;
      o_valid[k]             = full && valid[k];
      o_count                = o_count + CW'(full && valid[k]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pkt_buf  <= '0;
      full     <= 1'b0;
      ptr      <= '0;
      pend_off <= '0;
`ifdef FETCH_ALIGN_CARRY_EN
      carry    <= '0;
      carry_v  <= 1'b0;
`endif
    end else if (i_flush) begin
      full     <= 1'b0;
      ptr      <= '0;
      pend_off <= i_flush_offset;
`ifdef FETCH_ALIGN_CARRY_EN
      carry_v  <= 1'b0;
`endif
    end else begin
      if (xfer) ptr <= next_ptr;
`ifdef FETCH_ALIGN_CARRY_EN
      if (xfer && join_v) carry_v <= 1'b0;
      if (drain && straddle) begin
        carry   <= halves[DWIDTH-1];
        carry_v <= 1'b1;
      end
`endif
      if (drain) full <= 1'b0;
      if (accept) begin
        pkt_buf  <= i_packet;
        full     <= 1'b1;
        ptr      <= PW'(pend_off);
        pend_off <= '0;
`ifdef FETCH_ALIGN_CARRY_EN
        // A redirect target never joins with a half left over from before it.
        if (pend_off != '0) carry_v <= 1'b0;
`endif
      end
    end
  end

endmodule
